// File: rtl/load_store_unit_if.sv
// Single-master Avalon-style memory bus between the load/store unit and memory.
// master = load_store_unit side, slave = memory / bus-model side.
interface load_store_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;

  modport master (
    output mem_addr, mem_wdata, mem_byteenable, mem_read, mem_write,
    input  mem_rdata, mem_waitrequest
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_byteenable, mem_read, mem_write,
    output mem_rdata, mem_waitrequest
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one byte/half/word load or store per request over an
// Avalon-style bus with wait-states; misaligned, illegal-width and timeout faults.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               address,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         mem,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               load_data,
  output logic                      fault,
  output logic [1:0]                fault_cause,
  output logic [1:0]                state_dbg
);
  // Handshakes: a request is taken only when start=1 while busy=0 (start while
  // busy is dropped, never queued); on the bus a command completes in the first
  // cycle it is asserted with mem_waitrequest=0, otherwise it is held unchanged.

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_t;

  localparam logic [31:0] TLAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] tcnt;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  assign state_dbg = state;

  // Request decode from the live inputs, used only on the accepting edge.
  always_comb begin
    illegal    = is_store ? (funct3 > 3'd2) : ((funct3 == 3'd3) || (funct3 > 3'd5));
    misaligned = ((funct3[1:0] == 2'd1) && address[0]) ||
                 ((funct3[1:0] == 2'd2) && (address[1:0] != 2'b00));
    be_n       = 4'b1111;
    wdata_n    = store_data;
    case (funct3[1:0])
      2'd0: begin
        be_n    = 4'b0001 << address[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      2'd1: begin
        be_n    = address[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{store_data[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = store_data;
      end
    endcase
  end

  always_comb begin
    byte_v = mem.mem_rdata[{off_q, 3'b000} +: 8];
    half_v = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  ext_v = {24'd0, byte_v};
      3'b001:  ext_v = {{16{half_v[15]}}, half_v};
      3'b101:  ext_v = {16'd0, half_v};
      default: ext_v = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      funct3_q           <= 3'd0;
      off_q              <= 2'd0;
      tcnt               <= 32'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      fault              <= 1'b0;
      fault_cause        <= 2'd0;
      load_data          <= 32'd0;
      mem.mem_addr       <= 32'd0;
      mem.mem_wdata      <= 32'd0;
      mem.mem_byteenable <= 4'd0;
      mem.mem_read       <= 1'b0;
      mem.mem_write      <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            funct3_q <= funct3;
            off_q    <= address[1:0];
            busy     <= 1'b1;
            if (illegal || misaligned) begin
              state       <= S_FAULT;
              fault       <= 1'b1;
              fault_cause <= illegal ? 2'b10 : 2'b01;
            end else begin
              state              <= S_ACCESS;
              tcnt               <= 32'd0;
              mem.mem_addr       <= {address[31:2], 2'b00};
              mem.mem_wdata      <= wdata_n;
              mem.mem_byteenable <= be_n;
              mem.mem_read       <= !is_store;
              mem.mem_write      <= is_store;
            end
          end
        end
        S_ACCESS: begin
          if (!mem.mem_waitrequest) begin
            if (mem.mem_read) load_data <= ext_v;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            done          <= 1'b1;
            state         <= S_DONE;
          end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            fault         <= 1'b1;
            fault_cause   <= 2'b11;
            state         <= S_FAULT;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        S_DONE, S_FAULT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a byte-level
// reference model of RV32I load/store lane rules and fault priority.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_load;
  logic [1:0]  exp_cause;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_store    (is_store),
    .funct3      (funct3),
    .address     (address),
    .store_data  (store_data),
    .mem         (bus.master),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [1:0] model_cause(input logic st, input logic [2:0] f3,
                                             input logic [31:0] a);
    int nb;
    if (st && f3 > 3'd2) return 2'b10;
    if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b10;
    nb = 1 << f3[1:0];
    if ((a % nb) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return 32'(d[7:0]) * 32'h01010101;
      2'd1:    return 32'(d[15:0]) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint one;
    longint v;
    int nb;
    one = 1;
    nb  = 1 << f3[1:0];
    v   = longint'(rd >> (8 * (a % 4)));
    if (nb < 4) begin
      v = v % (one << (8 * nb));
      if (!f3[2] && v >= (one << (8 * nb - 1))) v = v - (one << (8 * nb));
    end
    return 32'(v);
  endfunction

  // One complete request; bus replies after `waits` stall cycles.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int waits);
    logic [1:0] cause;
    cause = model_cause(st, f3, a);
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; address = a; store_data = d;
    bus.mem_waitrequest = (waits > 0);
    bus.mem_rdata = rd;
    @(negedge clk);
    start = 1'b0;
    if (cause != 2'b00) begin
      exp_cause = cause;
      check("fault_pulse", 32'(fault), 32'd1);
      check("fault_cause", 32'(fault_cause), 32'(cause));
      check("fault_no_read", 32'(bus.mem_read), 32'd0);
      check("fault_no_write", 32'(bus.mem_write), 32'd0);
      check("fault_no_done", 32'(done), 32'd0);
      @(negedge clk);
      check("fault_end", 32'(fault), 32'd0);
      check("fault_idle", 32'(busy), 32'd0);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        check("cmd_read", 32'(bus.mem_read), 32'(!st));
        check("cmd_write", 32'(bus.mem_write), 32'(st));
        check("cmd_addr", bus.mem_addr, {a[31:2], 2'b00});
        check("cmd_be", 32'(bus.mem_byteenable), 32'(model_be(f3, a)));
        if (st) check("cmd_wdata", bus.mem_wdata, model_wdata(f3, d));
        check("cmd_busy", 32'(busy), 32'd1);
        check("cmd_no_done", 32'(done), 32'd0);
        bus.mem_waitrequest = (i < waits);
        @(negedge clk);
      end
      if (!st) exp_load = model_load(f3, a, rd);
      check("done_pulse", 32'(done), 32'd1);
      check("done_cmd_off", 32'(bus.mem_read | bus.mem_write), 32'd0);
      check("done_no_fault", 32'(fault), 32'd0);
      @(negedge clk);
      check("done_end", 32'(done), 32'd0);
      check("done_idle", 32'(busy), 32'd0);
    end
    check("load_data", load_data, exp_load);
    check("cause_hold", 32'(fault_cause), 32'(exp_cause));
    bus.mem_waitrequest = 1'b0;
  endtask

  initial begin
    int cnt;
    logic got_fault;
    logic st_r;
    logic [31:0] a_r;

    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    address = 32'd0; store_data = 32'd0;
    bus.mem_rdata = 32'd0; bus.mem_waitrequest = 1'b0;
    exp_load = 32'd0; exp_cause = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd", 32'(bus.mem_read | bus.mem_write), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_be", 32'(bus.mem_byteenable), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_req(1'b0, 3'b000, 32'h1003, 32'd0, 32'h80AA55CC, 0);
    check("lb_value", load_data, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h2002, 32'd0, 32'hBEEF1234, 3);
    check("lhu_value", load_data, 32'h0000BEEF);
    do_req(1'b1, 3'b000, 32'h11, 32'h123456A7, 32'd0, 0);
    do_req(1'b1, 3'b001, 32'h12, 32'h123456A7, 32'd0, 1);
    do_req(1'b0, 3'b010, 32'h6, 32'd0, 32'd0, 0);
    check("lw_mis_cause", 32'(fault_cause), 32'd1);
    do_req(1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 0);
    do_req(1'b1, 3'b100, 32'h0, 32'd0, 32'd0, 0);
    do_req(1'b0, 3'b011, 32'h1, 32'd0, 32'd0, 0);
    check("prio_cause", 32'(fault_cause), 32'd2);

    // Timeout with a start pulsed mid-access
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h100;
    bus.mem_waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; got_fault = 1'b0;
    for (int i = 0; i < 40 && !got_fault; i++) begin
      if (bus.mem_read) cnt++;
      if (fault) begin
        got_fault = 1'b1;
        check("to_cmd_off", 32'(bus.mem_read), 32'd0);
        check("to_cause", 32'(fault_cause), 32'd3);
      end
      if (i == 5) begin start = 1'b1; is_store = 1'b1; funct3 = 3'b111; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    check("to_seen", 32'(got_fault), 32'd1);
    check("to_len", 32'(cnt), 32'd16);
    check("to_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("to_no_queue", 32'(fault | busy), 32'd0);
    check("to_cause_hold", 32'(fault_cause), 32'd3);
    exp_cause = 2'b11;
    bus.mem_waitrequest = 1'b0;

    // Reset during ACCESS
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h40;
    bus.mem_waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_read", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_read", 32'(bus.mem_read), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", bus.mem_addr, 32'd0);
    check("arst_load", load_data, 32'd0);
    check("arst_cause", 32'(fault_cause), 32'd0);
    exp_load = 32'd0; exp_cause = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_waitrequest = 1'b0;
    @(negedge clk);
    check("arst_no_done", 32'(done | fault), 32'd0);
    do_req(1'b0, 3'b010, 32'h0, 32'd0, 32'hCAFEF00D, 0);

    // Randomized requests
    for (int n = 0; n < 60; n++) begin
      st_r = 1'($urandom_range(0, 1));
      a_r  = $urandom;
      do_req(st_r, 3'($urandom_range(0, 7)), a_r, $urandom, $urandom,
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the register/ALU datapath. It takes the ALU result as the effective address and the rs2 read value as store data, and performs one RV32I load or store (byte, half, word; signed/unsigned) over a single-master Avalon-style bus with wait-states. Load data is returned extended to 32 bits, ready for the register-file write port. Misaligned accesses, illegal width codes and bus timeouts are reported as faults instead of being issued.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles before abort; 0 disables the timeout.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; latched with start.
- funct3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only for stores.
- address  in  32  effective byte address (ALU result); latched with start.
- store_data  in  32  rs2 value; latched with start.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_byteenable  out  4  active byte lanes.
- mem_read / mem_write  out  1 each  bus command, mutually exclusive.
- mem_rdata  in  32  read data, valid in the cycle mem_waitrequest=0.
- mem_waitrequest  in  1  1 = slave stalls the current command.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; holds until the next load completes.
- fault  out  1  one-cycle fault pulse; done is not asserted for a faulted request.
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; holds until the next fault.

## Operation
- States: IDLE, ACCESS, DONE, FAULT. All outputs are registered.
- IDLE + start=1:
  - Latch is_store, funct3, address and store_data.
  - Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010) -> FAULT, cause 10.
  - Otherwise, misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) -> FAULT, cause 01. Illegal funct3 takes priority over misaligned.
  - Otherwise -> ACCESS.
- IDLE + start=0: stay in IDLE.
- ACCESS:
  - mem_read=!is_store, mem_write=is_store.
  - mem_addr, mem_byteenable and mem_wdata stay constant for the whole state.
  - A cycle with mem_waitrequest=0 is the transfer cycle. For a load, mem_rdata is captured and extended into load_data at that edge. Next state is DONE.
- Timeout: counter cleared on ACCESS entry, incremented each ACCESS cycle with mem_waitrequest=1. If mem_waitrequest=1 and counter==TIMEOUT-1 -> FAULT, cause 11. No data is captured.
- DONE: done=1 for one cycle -> IDLE. FAULT: fault=1 for one cycle -> IDLE.
- Lane rules (little-endian, o=addr[1:0]):
  - B/BU/SB: byteenable = 0001<<o; wdata = {4{d[7:0]}}.
  - H/HU/SH: byteenable = 0011 (o=0) or 1100 (o=2); wdata = {2{d[15:0]}}.
  - W/SW: byteenable = 1111; wdata = d.
  - Load extract: byte = rdata[8o+:8]; half = rdata[8o+:16]. B/H sign-extend; BU/HU zero-extend; W passes through.
- start while busy=1 is ignored and never queued.

## Timing
- Reset (asynchronous, effective immediately): state IDLE; busy, done, fault, mem_read and mem_write all 0; mem_addr, mem_wdata, mem_byteenable, load_data and fault_cause all 0; timeout counter 0.
- Reset during ACCESS drops mem_read/mem_write at once; no done or fault is produced.
- Zero-wait access: start sampled at edge 0; command visible cycle 1; done=1 in cycle 2; busy=0 in cycle 3. Each wait state adds one cycle.
- Fault at start: fault=1 in cycle 1; no bus command is ever asserted.
- Timeout: command is held for exactly TIMEOUT cycles; fault=1 in the next cycle with the command deasserted.
- The next start is accepted in the cycle busy=0 (minimum 3-cycle issue interval).

## Test plan
- LB: address=0x1003, mem_rdata=0x80AA55CC, no waits -> mem_addr 0x1000, byteenable 1000, done in cycle 2, load_data 0xFFFFFF80.
- LHU: address=0x2002, mem_rdata=0xBEEF1234, 3 wait cycles -> read held 4 cycles, load_data 0x0000BEEF, done in cycle 5.
- SB: address=0x11, store_data=0x123456A7 -> mem_write, mem_addr 0x10, byteenable 0010, wdata 0xA7A7A7A7; SH at 0x12 -> byteenable 1100, wdata 0x56A756A7.
- Faults:
  - LW at 0x6: fault=1, cause 01, no mem_read.
  - funct3=011 load: cause 10.
  - funct3=100 store: cause 10.
  - funct3=011 load at 0x1: cause 10 (funct3 priority).
- TIMEOUT=16, waitrequest stuck at 1: mem_read high exactly 16 cycles, then fault with cause 11. A start pulsed mid-access is ignored.
- Assert rst during ACCESS: mem_read falls asynchronously, all outputs 0, no done; a subsequent LW at 0x0 completes normally.
